// File: rtl/seq_divider_if.sv
// Run/Done handshake and operand/result bus for the sequential divider.
interface seq_divider_if #(
   parameter int unsigned WIDTH = 8
);
   logic             run;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             done;
   logic             div_by_zero;

   modport master (
      output run, dividend, divisor,
      input  quotient, remainder, done, div_by_zero
   );

   modport slave (
      input  run, dividend, divisor,
      output quotient, remainder, done, div_by_zero
   );
endinterface

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per clock, Run/Done handshake.
// Define SIGNED_DIV_EN for two's-complement operands (adds a FIXUP state).
module seq_divider #(
   parameter int unsigned WIDTH = 8
) (
   input logic          clk,
   input logic          reset,
   seq_divider_if.slave bus
);

   localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef SIGNED_DIV_EN
   typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
`endif

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   r, r_nxt;
   logic [WIDTH-1:0]   q, q_nxt;
   logic [WIDTH-1:0]   d, d_nxt;
   logic [CNT_W-1:0]   count, count_nxt;
   logic               done, done_nxt;
   logic               dbz, dbz_nxt;
   logic [WIDTH:0]     t_c, diff_c;
   logic               last_c;
   logic               div_zero_c;
`ifdef SIGNED_DIV_EN
   logic               neg_q, neg_q_nxt;
   logic               neg_r, neg_r_nxt;
   logic [WIDTH-1:0]   a_mag_c, b_mag_c;

   assign a_mag_c = bus.dividend[WIDTH-1] ? WIDTH'(-bus.dividend) : bus.dividend;
   assign b_mag_c = bus.divisor[WIDTH-1]  ? WIDTH'(-bus.divisor)  : bus.divisor;
`endif

   // Shift next dividend bit into the partial remainder and trial-subtract.
   assign t_c        = {r, q[WIDTH-1]};
   assign diff_c     = t_c - {1'b0, d};
   assign last_c     = (count == CNT_W'(WIDTH - 1));
   assign div_zero_c = (bus.divisor == '0);

   // State and datapath registers; reset wins over everything.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         r     <= '0;
         q     <= '0;
         d     <= '0;
         count <= '0;
         done  <= 1'b0;
         dbz   <= 1'b0;
`ifdef SIGNED_DIV_EN
         neg_q <= 1'b0;
         neg_r <= 1'b0;
`endif
      end else begin
         state <= state_nxt;
         r     <= r_nxt;
         q     <= q_nxt;
         d     <= d_nxt;
         count <= count_nxt;
         done  <= done_nxt;
         dbz   <= dbz_nxt;
`ifdef SIGNED_DIV_EN
         neg_q <= neg_q_nxt;
         neg_r <= neg_r_nxt;
`endif
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (bus.run) state_nxt = div_zero_c ? DONE : CALC;
`ifdef SIGNED_DIV_EN
         CALC:  if (last_c) state_nxt = FIXUP;
         FIXUP: state_nxt = DONE;
`else
         CALC:  if (last_c) state_nxt = DONE;
`endif
         DONE: if (!bus.run) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Next values for datapath and status registers.
   always_comb begin
      r_nxt     = r;
      q_nxt     = q;
      d_nxt     = d;
      count_nxt = count;
      done_nxt  = done;
      dbz_nxt   = dbz;
`ifdef SIGNED_DIV_EN
      neg_q_nxt = neg_q;
      neg_r_nxt = neg_r;
`endif
      case (state)
         IDLE: begin
            if (bus.run) begin
               if (div_zero_c) begin
                  q_nxt    = '1;
                  r_nxt    = bus.dividend;
                  dbz_nxt  = 1'b1;
                  done_nxt = 1'b1;
               end else begin
                  r_nxt     = '0;
                  count_nxt = '0;
`ifdef SIGNED_DIV_EN
                  q_nxt     = a_mag_c;
                  d_nxt     = b_mag_c;
                  neg_q_nxt = bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
                  neg_r_nxt = bus.dividend[WIDTH-1];
`else
                  q_nxt     = bus.dividend;
                  d_nxt     = bus.divisor;
`endif
               end
            end
         end
         CALC: begin
            if (!diff_c[WIDTH]) begin
               r_nxt = diff_c[WIDTH-1:0];
               q_nxt = {q[WIDTH-2:0], 1'b1};
            end else begin
               r_nxt = t_c[WIDTH-1:0];
               q_nxt = {q[WIDTH-2:0], 1'b0};
            end
            count_nxt = CNT_W'(count + 1'b1);
`ifndef SIGNED_DIV_EN
            if (last_c) done_nxt = 1'b1;
`endif
         end
`ifdef SIGNED_DIV_EN
         FIXUP: begin
            if (neg_q) q_nxt = WIDTH'(-q);
            if (neg_r) r_nxt = WIDTH'(-r);
            done_nxt = 1'b1;
         end
`endif
         DONE: begin
            if (!bus.run) begin
               done_nxt = 1'b0;
               dbz_nxt  = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign bus.quotient    = q;
   assign bus.remainder   = r;
   assign bus.done        = done;
   assign bus.div_by_zero = dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed plus random checks of seq_divider against an arithmetic reference model.
module tb_seq_divider;

   localparam int unsigned WIDTH = 8;
`ifdef SIGNED_DIV_EN
   localparam int LAT = WIDTH + 2;
`else
   localparam int LAT = WIDTH + 1;
`endif

   logic clk;
   logic reset;
   int   n_chk;
   int   n_fail;

   seq_divider_if #(.WIDTH(WIDTH)) bus ();

   seq_divider #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Quotient/remainder straight from integer division rules.
   function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] eq, output logic [7:0] er);
      int sa, sb;
`ifdef SIGNED_DIV_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
`else
      sa = int'(a);
      sb = int'(b);
`endif
      if (sb == 0) begin
         eq = 8'hFF;
         er = a;
      end else begin
         eq = 8'(sa / sb);
         er = 8'(sa % sb);
      end
   endfunction

   task automatic run_div(input logic [7:0] a, input logic [7:0] b, input int hold);
      logic [7:0] eq, er;
      int n;
      model(a, b, eq, er);
      bus.dividend = a;
      bus.divisor  = b;
      bus.run      = 1'b1;
      tick();
      n = 1;
      bus.dividend = 8'($urandom);
      bus.divisor  = 8'($urandom);
      while (bus.done !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      chk("latency", 32'(n), 32'((b == 8'd0) ? 1 : LAT));
      chk("quotient", 32'(bus.quotient), 32'(eq));
      chk("remainder", 32'(bus.remainder), 32'(er));
      chk("div_by_zero", 32'(bus.div_by_zero), 32'(b == 8'd0));
      for (int i = 0; i < hold; i++) begin
         tick();
         chk("hold_done", 32'(bus.done), 32'd1);
         chk("hold_quotient", 32'(bus.quotient), 32'(eq));
         chk("hold_remainder", 32'(bus.remainder), 32'(er));
      end
      bus.run = 1'b0;
      tick();
      chk("idle_done", 32'(bus.done), 32'd0);
      chk("idle_dbz", 32'(bus.div_by_zero), 32'd0);
      chk("idle_quotient", 32'(bus.quotient), 32'(eq));
      chk("idle_remainder", 32'(bus.remainder), 32'(er));
   endtask

   initial begin
      logic [7:0] ra, rb;
      n_chk        = 0;
      n_fail       = 0;
      reset        = 1'b1;
      bus.run      = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      tick();
      tick();
      chk("rst_quotient", 32'(bus.quotient), 32'd0);
      chk("rst_remainder", 32'(bus.remainder), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
      reset = 1'b0;
      tick();

      run_div(8'd100, 8'd7, 3);
      run_div(8'hFF, 8'd1, 0);
      run_div(8'd3, 8'd10, 0);
      run_div(8'd5, 8'd0, 1);

      // Reset landing on the 4th CALC edge aborts the division.
      bus.dividend = 8'd200;
      bus.divisor  = 8'd3;
      bus.run      = 1'b1;
      tick();
      for (int i = 0; i < 3; i++) tick();
      reset = 1'b1;
      tick();
      chk("abort_quotient", 32'(bus.quotient), 32'd0);
      chk("abort_remainder", 32'(bus.remainder), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_dbz", 32'(bus.div_by_zero), 32'd0);
      reset   = 1'b0;
      bus.run = 1'b0;
      tick();
      run_div(8'd9, 8'd4, 0);

      // Run held through DONE must not restart.
      run_div(8'd9, 8'd4, 5);
      run_div(8'd9, 8'd4, 0);

`ifdef SIGNED_DIV_EN
      run_div(8'hF9, 8'd2, 0);
      run_div(8'h80, 8'hFF, 0);
      run_div(8'h80, 8'd1, 0);
      run_div(8'd127, 8'hF0, 0);
`endif

      for (int i = 0; i < 40; i++) begin
         ra = 8'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
         run_div(ra, rb, int'($urandom_range(0, 2)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
